// File: rtl/wdt_ctrl_if.sv
// Request/response bus port of the watchdog control block.
// The master issues register accesses and the slave answers each one with a single response.
interface wdt_ctrl_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [4:0]  REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );
endinterface

// File: rtl/wdt_ctrl.sv
// Watchdog front end. It holds a key-protected register file that drives WDEN, WDLIVE and WTOCNT.
// It also escalates a persistent WTO into an interrupt and then into a sticky system reset request.
module wdt_ctrl #(
  parameter logic [31:0] KEY       = 32'h5A5A_A5A5,
  parameter logic [31:0] TOCNT_RST = 32'hFFFF_FFFF,
  parameter int unsigned GRACE     = 1024
) (
  input  logic        CLK,
  input  logic        RSTn,
  wdt_ctrl_if.slave   bus,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  input  logic        WTO,
  output logic        WDT_IRQ,
  output logic        WDT_RST_REQ
);

  typedef enum logic {B_IDLE, B_RESP} bus_state_e;
  typedef enum logic [1:0] {E_IDLE, E_GRACE, E_RESET} esc_state_e;

  localparam logic [15:0] GRACE_LAST = 16'(GRACE - 1);

  bus_state_e  bst_q, bst_d;
  esc_state_e  est_q, est_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic        ctrl_irq_en_q, ctrl_irq_en_d;
  logic        ctrl_rst_en_q, ctrl_rst_en_d;
  logic [31:0] tocnt_q, tocnt_d;
  logic        unlocked_q, unlocked_d;
  logic        wdlive_q, wdlive_d;
  logic        to_sticky_q, to_sticky_d;
  logic [15:0] grace_cnt_q, grace_cnt_d;
  logic        irq_q, irq_d;
  logic        sticky_w1c;
  logic        accept;
  logic [2:0]  reg_idx;
  logic [31:0] status_val;
  logic        unused_addr_bits;

  assign accept           = bus.REQ_VALID && (bst_q == B_IDLE);
  assign reg_idx          = bus.REQ_ADDR[4:2];
  assign unused_addr_bits = ^bus.REQ_ADDR[1:0];
  assign status_val       = {14'b0, grace_cnt_q, (est_q == E_RESET), to_sticky_q};

  always_comb begin
    bst_d         = bst_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    ctrl_en_d     = ctrl_en_q;
    ctrl_irq_en_d = ctrl_irq_en_q;
    ctrl_rst_en_d = ctrl_rst_en_q;
    tocnt_d       = tocnt_q;
    unlocked_d    = unlocked_q;
    wdlive_d      = 1'b0;
    sticky_w1c    = 1'b0;
    case (bst_q)
      B_IDLE: begin
        if (accept) begin
          bst_d       = B_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (bus.REQ_WRITE) begin
            case (reg_idx)
              3'd0, 3'd1: begin
                // Any CTRL/TOCNT write consumes the unlock, whether or not it lands.
                unlocked_d = 1'b0;
                if (!unlocked_q) begin
                  rsp_err_d = 1'b1;
                end else if (reg_idx == 3'd0) begin
                  ctrl_en_d     = bus.REQ_WDATA[0];
                  ctrl_irq_en_d = bus.REQ_WDATA[1];
                  ctrl_rst_en_d = bus.REQ_WDATA[2];
                end else begin
                  tocnt_d = bus.REQ_WDATA;
                end
              end
              3'd2: begin
                if (bus.REQ_WDATA == KEY) wdlive_d  = 1'b1;
                else                      rsp_err_d = 1'b1;
              end
              3'd3:    unlocked_d = (bus.REQ_WDATA == KEY);
              3'd4:    sticky_w1c = bus.REQ_WDATA[0];
              default: rsp_err_d  = 1'b1;
            endcase
          end else begin
            case (reg_idx)
              3'd0:    rsp_rdata_d = {29'b0, ctrl_rst_en_q, ctrl_irq_en_q, ctrl_en_q};
              3'd1:    rsp_rdata_d = tocnt_q;
              3'd2:    rsp_rdata_d = '0;
              3'd3:    rsp_rdata_d = {31'b0, unlocked_q};
              3'd4:    rsp_rdata_d = status_val;
              default: rsp_err_d   = 1'b1;
            endcase
          end
        end
      end
      B_RESP: begin
        if (bus.RSP_READY) bst_d = B_IDLE;
      end
      default: bst_d = B_IDLE;
    endcase
  end

  always_comb begin
    est_d       = est_q;
    grace_cnt_d = grace_cnt_q;
    // A WTO sample at the same edge as a W1C wins, so the flag cannot be lost.
    to_sticky_d = (to_sticky_q && !sticky_w1c) || WTO;
    case (est_q)
      E_IDLE: begin
        if (WTO) begin
          est_d       = E_GRACE;
          grace_cnt_d = '0;
        end
      end
      E_GRACE: begin
        if (!WTO) begin
          est_d       = E_IDLE;
          grace_cnt_d = '0;
        end else if (grace_cnt_q == GRACE_LAST) begin
          if (ctrl_rst_en_q) est_d = E_RESET;
        end else begin
          grace_cnt_d = grace_cnt_q + 16'd1;
        end
      end
      E_RESET: est_d = E_RESET;
      default: est_d = E_IDLE;
    endcase
    irq_d = to_sticky_d && ctrl_irq_en_d;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bst_q         <= B_IDLE;
      est_q         <= E_IDLE;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      ctrl_en_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      ctrl_rst_en_q <= 1'b0;
      tocnt_q       <= TOCNT_RST;
      unlocked_q    <= 1'b0;
      wdlive_q      <= 1'b0;
      to_sticky_q   <= 1'b0;
      grace_cnt_q   <= '0;
      irq_q         <= 1'b0;
    end else begin
      bst_q         <= bst_d;
      est_q         <= est_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      ctrl_en_q     <= ctrl_en_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      ctrl_rst_en_q <= ctrl_rst_en_d;
      tocnt_q       <= tocnt_d;
      unlocked_q    <= unlocked_d;
      wdlive_q      <= wdlive_d;
      to_sticky_q   <= to_sticky_d;
      grace_cnt_q   <= grace_cnt_d;
      irq_q         <= irq_d;
    end
  end

  assign bus.REQ_READY = (bst_q == B_IDLE);
  assign bus.RSP_VALID = (bst_q == B_RESP);
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign WDEN          = ctrl_en_q;
  assign WDLIVE        = wdlive_q;
  assign WTOCNT        = tocnt_q;
  assign WDT_IRQ       = irq_q;
  assign WDT_RST_REQ   = (est_q == E_RESET);

endmodule
